// File: rtl/jtkicker_sdram_resp_pkg.sv
// Shared types and constants for the BRAM-backed SDRAM responder.
package jtkicker_sdram_resp_pkg;

    localparam int unsigned SDRAM_AW   = 22;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned REF_CYCLES = 4;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        DST     = 3'd2,
        RDY     = 3'd3,
        WR      = 3'd4,
        REF     = 3'd5
    } state_e;

endpackage

// File: rtl/jtkicker_sdram_resp_if.sv
// ROM-slot bus plus download port, as seen between arbiter (master) and memory (slave).
interface jtkicker_sdram_resp_if;
    import jtkicker_sdram_resp_pkg::*;

    logic                downloading;
    logic                sdram_req;
    logic [SDRAM_AW-1:0] sdram_addr;
    logic                sdram_ack;
    logic                data_dst;
    logic                data_rdy;
    logic [DATA_W-1:0]   data_read;
    logic                prog_we;
    logic [SDRAM_AW-1:0] prog_addr;
    logic [7:0]          prog_data;
    logic [1:0]          prog_mask;

    modport master (
        output downloading, sdram_req, sdram_addr, prog_we, prog_addr, prog_data, prog_mask,
        input  sdram_ack, data_dst, data_rdy, data_read
    );

    modport slave (
        input  downloading, sdram_req, sdram_addr, prog_we, prog_addr, prog_data, prog_mask,
        output sdram_ack, data_dst, data_rdy, data_read
    );

endinterface

// File: rtl/jtkicker_sdram_resp_ram.sv
// Single-port 2^AW x 16 block RAM, per-byte write enables, one-cycle registered read.
module jtkicker_sdram_resp_ram
    import jtkicker_sdram_resp_pkg::*;
#(
    parameter int unsigned AW = 17
) (
    input  logic              clk,
    input  logic              en,
    input  logic [1:0]        we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**AW];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we[0]) mem[addr][7:0]  <= wdata[7:0];
        if (we[1]) mem[addr][15:8] <= wdata[15:8];
        if (en)    rdata_q         <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/jtkicker_sdram_resp.sv
// SDRAM responder: serves 2-word read bursts and download writes from on-chip RAM.
// Optional emulated refresh stalls: define JTKICKER_SDRAM_RESP_REFRESH_EN.
module jtkicker_sdram_resp
    import jtkicker_sdram_resp_pkg::*;
#(
    parameter int unsigned MEM_AW     = 17,
    parameter int unsigned LATENCY    = 3,
    parameter int unsigned REF_PERIOD = 384
) (
    input  logic                  clk,
    input  logic                  rst,
    jtkicker_sdram_resp_if.slave  bus
);

    if (LATENCY < 2 || LATENCY > 15 || REF_PERIOD < 1) begin : g_bad_cfg
        $error("jtkicker_sdram_resp: LATENCY must be 2..15 and REF_PERIOD >= 1");
    end

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [MEM_AW-1:0]   addr_q, addr_d;
    logic                ack_q, ack_d;
    logic                dst_q, dst_d;
    logic                rdy_q, rdy_d;
    logic [DATA_W-1:0]   data_read_q, data_read_d;

    logic                ram_en_c;
    logic [1:0]          ram_we_c;
    logic [MEM_AW-1:0]   ram_addr_c;
    logic [DATA_W-1:0]   ram_wdata_c;
    logic [DATA_W-1:0]   ram_rdata;

    logic                unused_c;
    assign unused_c = ^{bus.sdram_addr[SDRAM_AW-1:MEM_AW], bus.prog_addr[SDRAM_AW-1:MEM_AW]};

`ifdef JTKICKER_SDRAM_RESP_REFRESH_EN
    localparam int unsigned REF_W = $clog2(REF_PERIOD + 1);

    logic [REF_W-1:0] ref_cnt_q, ref_cnt_d;
    logic             ref_pend_q, ref_pend_d;
    logic             ref_clr_c;
    logic             ref_wrap_c;

    // Free-running refresh timer; a wrap arms a refresh that the FSM takes at its next IDLE.
    always_comb begin
        ref_wrap_c = (ref_cnt_q == REF_W'(REF_PERIOD - 1));
        ref_cnt_d  = ref_wrap_c ? '0 : ref_cnt_q + REF_W'(1);
        ref_pend_d = ref_wrap_c | (ref_pend_q & ~ref_clr_c);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ref_cnt_q  <= '0;
            ref_pend_q <= 1'b0;
        end else begin
            ref_cnt_q  <= ref_cnt_d;
            ref_pend_q <= ref_pend_d;
        end
    end
`endif

    // Outputs are registered, so each state prepares the pulse seen in the following cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        ack_d       = 1'b0;
        dst_d       = 1'b0;
        rdy_d       = 1'b0;
        data_read_d = data_read_q;
        ram_en_c    = 1'b0;
        ram_we_c    = 2'b00;
        ram_addr_c  = addr_q;
        ram_wdata_c = {bus.prog_data, bus.prog_data};
`ifdef JTKICKER_SDRAM_RESP_REFRESH_EN
        ref_clr_c   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
`ifdef JTKICKER_SDRAM_RESP_REFRESH_EN
                if (ref_pend_q) begin
                    state_d = REF;
                    cnt_d   = CNT_W'(REF_CYCLES - 1);
                end else
`endif
                if (bus.downloading && bus.prog_we) begin
                    state_d    = WR;
                    ack_d      = 1'b1;
                    ram_addr_c = bus.prog_addr[MEM_AW-1:0];
                    ram_we_c   = ~bus.prog_mask;
                end else if (!bus.downloading && bus.sdram_req) begin
                    state_d = RD_WAIT;
                    ack_d   = 1'b1;
                    cnt_d   = LAT_LOAD;
                    addr_d  = bus.sdram_addr[MEM_AW-1:0];
                end
            end
            RD_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    ram_en_c = 1'b1;
                    state_d  = DST;
                end
            end
            DST: begin
                dst_d       = 1'b1;
                data_read_d = ram_rdata;
                ram_en_c    = 1'b1;
                ram_addr_c  = addr_q + MEM_AW'(1);
                state_d     = RDY;
            end
            RDY: begin
                rdy_d       = 1'b1;
                data_read_d = ram_rdata;
                state_d     = IDLE;
            end
            WR: state_d = IDLE;
`ifdef JTKICKER_SDRAM_RESP_REFRESH_EN
            REF: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    ref_clr_c = 1'b1;
                    state_d   = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            ack_q       <= 1'b0;
            dst_q       <= 1'b0;
            rdy_q       <= 1'b0;
            data_read_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            ack_q       <= ack_d;
            dst_q       <= dst_d;
            rdy_q       <= rdy_d;
            data_read_q <= data_read_d;
        end
    end

    assign bus.sdram_ack = ack_q;
    assign bus.data_dst  = dst_q;
    assign bus.data_rdy  = rdy_q;
    assign bus.data_read = data_read_q;

    jtkicker_sdram_resp_ram #(.AW(MEM_AW)) u_ram (
        .clk   (clk),
        .en    (ram_en_c),
        .we    (ram_we_c),
        .addr  (ram_addr_c),
        .wdata (ram_wdata_c),
        .rdata (ram_rdata)
    );

endmodule
